// File: rtl/fdivsqrt_intpreproc_seq_if.sv
// Handshake and operand/result bundle between the IEU forwarding stage,
// the integer preprocessor and the divsqrt FSM/iterator.
interface fdivsqrt_intpreproc_seq_if #(
    parameter int XLEN    = 64,
    parameter int DIVB    = 66,
    parameter int DIVBLEN = $clog2(DIVB + 2)
);
    logic               InValid;
    logic               InReady;
    logic               Abort;
    logic [XLEN-1:0]    ForwardedSrcAE;
    logic [XLEN-1:0]    ForwardedSrcBE;
    logic [2:0]         Funct3E;
    logic               W64E;
    logic               OutValid;
    logic               OutReady;
    logic [DIVB+3:0]    X;
    logic [DIVB+3:0]    D;
    logic [DIVBLEN-1:0] CyclesM;
    logic [DIVBLEN-1:0] IntNormShiftM;
    logic               ISpecialCaseM;
    logic               ALTBM;
    logic               BZeroM;
    logic               AsM;
    logic               BsM;
    logic               W64M;
    logic [XLEN-1:0]    AM;

    modport master (
        output InValid, Abort, ForwardedSrcAE, ForwardedSrcBE, Funct3E, W64E, OutReady,
        input  InReady, OutValid, X, D, CyclesM, IntNormShiftM, ISpecialCaseM,
               ALTBM, BZeroM, AsM, BsM, W64M, AM
    );

    modport slave (
        input  InValid, Abort, ForwardedSrcAE, ForwardedSrcBE, Funct3E, W64E, OutReady,
        output InReady, OutValid, X, D, CyclesM, IntNormShiftM, ISpecialCaseM,
               ALTBM, BZeroM, AsM, BsM, W64M, AM
    );
endinterface

// File: rtl/fdivsqrt_intpreproc_seq.sv
// Multicycle integer-division preprocessor: conditions signed/W64 operands,
// normalizes them NSTEP bits per cycle and derives the iteration metadata
// (A<B, result bit count, iterator cycles, post-normalization shift).
module fdivsqrt_intpreproc_seq #(
    parameter int XLEN    = 64,
    parameter int DIVB    = 66,
    parameter int LOGR    = 2,
    parameter int RK      = 2,
    parameter int NSTEP   = 8,
    parameter int DIVBLEN = $clog2(DIVB + 2)
) (
    input logic                      clk,
    input logic                      reset,
    fdivsqrt_intpreproc_seq_if.slave bus
);
    localparam int SW     = DIVB + 1;              // normalizer width
    localparam int PAD    = DIVB - XLEN + 1;       // zeros appended below the operand
    localparam int LOG_RK = (RK > 1) ? $clog2(RK) : 0;

    typedef enum logic [1:0] {IDLE, NORM, ALIGN, DONE} state_t;

    state_t state;
    state_t state_next;

    // Returns the leading-zero count of one NSTEP-bit window, NSTEP if all zero.
    function automatic logic [DIVBLEN-1:0] lzc_step(input logic [NSTEP-1:0] v);
        logic [DIVBLEN-1:0] n;
        n = DIVBLEN'(NSTEP);
        for (int i = 0; i < NSTEP; i++) begin
            if (v[i]) n = DIVBLEN'(NSTEP - 1 - i);
        end
        return n;
    endfunction

    // Operand conditioning
    logic               signed_op;
    logic [XLEN-1:0]    ae;
    logic [XLEN-1:0]    be;
    logic [XLEN-1:0]    pos_a;
    logic [XLEN-1:0]    pos_b;
    logic               a_sign;
    logic               b_sign;
    logic               a_zero;
    logic               b_zero;
    logic               accept;
    logic [SW-1:0]      xs_load;
    logic [SW-1:0]      ds_load;

    // Normalizer state
    logic [SW-1:0]      xs;
    logic [SW-1:0]      ds;
    logic [DIVBLEN-1:0] ell;
    logic [DIVBLEN-1:0] m_e;
    logic               x_done;
    logic               d_done;
    logic               rem_op;
    logic [NSTEP-1:0]   x_top;
    logic [NSTEP-1:0]   d_top;
    logic [DIVBLEN-1:0] x_sh;
    logic [DIVBLEN-1:0] d_sh;
    logic               x_fin;
    logic               d_fin;

    // Alignment metadata
    logic [DIVBLEN-1:0] zero_diff;
    logic               altb;
    logic [DIVBLEN-1:0] p;
    logic [DIVBLEN-1:0] int_result_bits;
    logic [DIVBLEN-1:0] cycles;
    logic [DIVBLEN-1:0] right_shift_x;
    logic [DIVBLEN-1:0] int_norm_shift;
    logic [DIVB+3:0]    x_align;

    // Result registers
    logic [DIVB+3:0]    x_m;
    logic [DIVB+3:0]    d_m;
    logic [DIVBLEN-1:0] cycles_m;
    logic [DIVBLEN-1:0] int_norm_shift_m;
    logic               special_m;
    logic               altb_m;
    logic               bzero_m;
    logic               as_m;
    logic               bs_m;
    logic               w64_m;
    logic [XLEN-1:0]    a_m;
    logic               in_ready;
    logic               out_valid;

    assign signed_op = ~bus.Funct3E[0];

    generate
        if (XLEN == 64) begin : g_w64
            // Narrow 32-bit ops to the low word, sign- or zero-extended.
            always_comb begin
                ae = bus.ForwardedSrcAE;
                be = bus.ForwardedSrcBE;
                if (bus.W64E) begin
                    ae = {{(XLEN-32){signed_op & bus.ForwardedSrcAE[31]}}, bus.ForwardedSrcAE[31:0]};
                    be = {{(XLEN-32){signed_op & bus.ForwardedSrcBE[31]}}, bus.ForwardedSrcBE[31:0]};
                end
            end
        end else begin : g_nw64
            assign ae = bus.ForwardedSrcAE;
            assign be = bus.ForwardedSrcBE;
        end
    endgenerate

    assign a_sign  = ae[XLEN-1] & signed_op;
    assign b_sign  = be[XLEN-1] & signed_op;
    assign pos_a   = a_sign ? (XLEN'(0) - ae) : ae;
    assign pos_b   = b_sign ? (XLEN'(0) - be) : be;
    assign a_zero  = (ae == '0);
    assign b_zero  = (be == '0);
    assign xs_load = SW'(pos_a) << PAD;
    assign ds_load = SW'(pos_b) << PAD;
    assign accept  = (state == IDLE) & bus.InValid & ~bus.Abort;

    // One normalization step: a zero window shifts by NSTEP, otherwise the
    // window's lzc finishes that operand.
    assign x_top = xs[DIVB -: NSTEP];
    assign d_top = ds[DIVB -: NSTEP];
    assign x_sh  = lzc_step(x_top);
    assign d_sh  = lzc_step(d_top);
    assign x_fin = x_done | (x_top != '0);
    assign d_fin = d_done | (d_top != '0);

    // Derive result-size metadata from the two leading-zero counts.
    always_comb begin
        zero_diff       = m_e - ell;
        altb            = zero_diff[DIVBLEN-1];
        p               = altb ? '0 : zero_diff;
        int_result_bits = DIVBLEN'(LOGR) + p;
        cycles          = DIVBLEN'(({1'b0, int_result_bits} + (DIVBLEN+1)'(RK - 1)) >> LOG_RK);
        if (RK == 1) begin
            right_shift_x = '0;
        end else begin
            right_shift_x = DIVBLEN'(RK - 1) - ((int_result_bits - 1'b1) & DIVBLEN'(RK - 1));
        end
        x_align = {3'b000, xs} >> right_shift_x;
        if (rem_op) begin
            int_norm_shift = m_e + DIVBLEN'(DIVB - (XLEN - 1));
        end else begin
            int_norm_shift = DIVBLEN'(DIVB) - ((cycles << LOG_RK) - DIVBLEN'(LOGR));
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; Abort outranks every advance.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (a_zero | b_zero) ? DONE : NORM;
            NORM:    if (bus.Abort) state_next = IDLE;
                     else if (x_fin & d_fin) state_next = ALIGN;
            ALIGN:   state_next = bus.Abort ? IDLE : DONE;
            DONE:    if (bus.Abort | bus.OutReady) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, normalization steps and result registration.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_m              <= '0;
            d_m              <= '0;
            cycles_m         <= '0;
            int_norm_shift_m <= '0;
            special_m        <= 1'b0;
            altb_m           <= 1'b0;
            bzero_m          <= 1'b0;
            as_m             <= 1'b0;
            bs_m             <= 1'b0;
            w64_m            <= 1'b0;
            a_m              <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    xs               <= xs_load;
                    ds               <= ds_load;
                    ell              <= '0;
                    m_e              <= '0;
                    x_done           <= 1'b0;
                    d_done           <= 1'b0;
                    rem_op           <= bus.Funct3E[1];
                    a_m              <= ae;
                    as_m             <= a_sign;
                    bs_m             <= b_sign;
                    w64_m            <= bus.W64E;
                    bzero_m          <= b_zero;
                    altb_m           <= a_zero & ~b_zero;
                    special_m        <= a_zero | b_zero;
                    x_m              <= '0;
                    d_m              <= '0;
                    cycles_m         <= '0;
                    int_norm_shift_m <= '0;
                end
                NORM: begin
                    if (!x_done) begin
                        xs     <= xs << x_sh;
                        ell    <= ell + x_sh;
                        x_done <= (x_top != '0);
                    end
                    if (!d_done) begin
                        ds     <= ds << d_sh;
                        m_e    <= m_e + d_sh;
                        d_done <= (d_top != '0);
                    end
                end
                ALIGN: begin
                    x_m              <= x_align;
                    d_m              <= {3'b000, ds};
                    cycles_m         <= cycles;
                    int_norm_shift_m <= int_norm_shift;
                    altb_m           <= altb;
                    special_m        <= bzero_m | altb;
                end
                default: ;
            endcase
        end
    end

    assign bus.InReady       = in_ready;
    assign bus.OutValid      = out_valid;
    assign bus.X             = x_m;
    assign bus.D             = d_m;
    assign bus.CyclesM       = cycles_m;
    assign bus.IntNormShiftM = int_norm_shift_m;
    assign bus.ISpecialCaseM = special_m;
    assign bus.ALTBM         = altb_m;
    assign bus.BZeroM        = bzero_m;
    assign bus.AsM           = as_m;
    assign bus.BsM           = bs_m;
    assign bus.W64M          = w64_m;
    assign bus.AM            = a_m;
endmodule

// File: tb/tb_fdivsqrt_intpreproc_seq.sv
// Directed table-driven bench for fdivsqrt_intpreproc_seq with default
// parameters (XLEN=64, DIVB=66, LOGR=2, RK=2, NSTEP=8).
module tb_fdivsqrt_intpreproc_seq;
    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    fdivsqrt_intpreproc_seq_if #(.XLEN(64), .DIVB(66), .DIVBLEN(7)) bus ();

    fdivsqrt_intpreproc_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  f3;
        logic        w64;
        logic [69:0] x;
        logic [69:0] d;
        logic [6:0]  cyc;
        logic [6:0]  ins;
        logic        spec;
        logic        altb;
        logic        bz;
        logic        a_s;
        logic        b_s;
        logic [63:0] am;
        int          lat;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " X"}, bus.X, 0);
        check({tag, " D"}, bus.D, 0);
        check({tag, " CyclesM"}, bus.CyclesM, 0);
        check({tag, " IntNormShiftM"}, bus.IntNormShiftM, 0);
        check({tag, " flags"}, {bus.ISpecialCaseM, bus.ALTBM, bus.BZeroM, bus.AsM, bus.BsM, bus.W64M}, 0);
        check({tag, " AM"}, bus.AM, 0);
        check({tag, " handshake"}, {bus.OutValid, bus.InReady}, 2'b01);
    endtask

    task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f3, input logic w64);
        bus.ForwardedSrcAE = a;
        bus.ForwardedSrcBE = b;
        bus.Funct3E        = f3;
        bus.W64E           = w64;
        bus.InValid        = 1'b1;
        @(posedge clk); #1;
        bus.InValid        = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.OutValid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        bus.OutReady = 1'b1;
        @(posedge clk); #1;
        bus.OutReady = 1'b0;
    endtask

    task automatic no_valid_for(input string nm, input int n);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            seen = seen | bus.OutValid;
        end
        check(nm, seen, 1'b0);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   lat;
        v = vecs[i];
        check($sformatf("v%0d InReady", i), bus.InReady, 1'b1);
        start_op(v.a, v.b, v.f3, v.w64);
        wait_valid(lat);
        check($sformatf("v%0d latency", i), lat, v.lat);
        check($sformatf("v%0d X", i), bus.X, v.x);
        check($sformatf("v%0d D", i), bus.D, v.d);
        check($sformatf("v%0d CyclesM", i), bus.CyclesM, v.cyc);
        check($sformatf("v%0d IntNormShiftM", i), bus.IntNormShiftM, v.ins);
        check($sformatf("v%0d ISpecialCaseM", i), bus.ISpecialCaseM, v.spec);
        check($sformatf("v%0d ALTBM", i), bus.ALTBM, v.altb);
        check($sformatf("v%0d BZeroM", i), bus.BZeroM, v.bz);
        check($sformatf("v%0d AsM/BsM", i), {bus.AsM, bus.BsM}, {v.a_s, v.b_s});
        check($sformatf("v%0d W64M", i), bus.W64M, v.w64);
        check($sformatf("v%0d AM", i), bus.AM, v.am);
        check($sformatf("v%0d InReady in DONE", i), bus.InReady, 1'b0);
        release_out();
        check($sformatf("v%0d back to idle", i), {bus.OutValid, bus.InReady}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          a                      b                      f3      w64   x                          d              cyc    ins    sp   altb bz   as   bs   am                     lat
        vecs[0]  = '{64'd100,              64'd7,                 3'b101, 1'b0, 70'd100 << 60,             70'd7 << 64,   7'd3,  7'd62, 1'b0,1'b0,1'b0,1'b0,1'b0, 64'd100,              10};
        vecs[1]  = '{64'h00000000FFFFFFF9, 64'd2,                 3'b100, 1'b1, 70'd7 << 63,               70'd1 << 66,   7'd2,  7'd64, 1'b0,1'b0,1'b0,1'b1,1'b0, 64'hFFFFFFFFFFFFFFF9, 10};
        vecs[2]  = '{64'd5,                64'd0,                 3'b111, 1'b0, 70'd0,                     70'd0,         7'd0,  7'd0,  1'b1,1'b0,1'b1,1'b0,1'b0, 64'd5,                1};
        vecs[3]  = '{64'd0,                64'd9,                 3'b111, 1'b0, 70'd0,                     70'd0,         7'd0,  7'd0,  1'b1,1'b1,1'b0,1'b0,1'b0, 64'd0,                1};
        vecs[4]  = '{64'd3,                64'd10,                3'b100, 1'b0, 70'd3 << 65,               70'd10 << 63,  7'd1,  7'd66, 1'b1,1'b1,1'b0,1'b0,1'b0, 64'd3,                10};
        vecs[5]  = '{64'd3,                64'd10,                3'b110, 1'b0, 70'd3 << 65,               70'd10 << 63,  7'd1,  7'd63, 1'b1,1'b1,1'b0,1'b0,1'b0, 64'd3,                10};
        vecs[6]  = '{64'hFFFFFFFFFFFFFF9C, 64'd7,                 3'b100, 1'b0, 70'd100 << 60,             70'd7 << 64,   7'd3,  7'd62, 1'b0,1'b0,1'b0,1'b1,1'b0, 64'hFFFFFFFFFFFFFF9C, 10};
        vecs[7]  = '{64'd100,              64'hFFFFFFFFFFFFFFF9,  3'b100, 1'b0, 70'd100 << 60,             70'd7 << 64,   7'd3,  7'd62, 1'b0,1'b0,1'b0,1'b0,1'b1, 64'd100,              10};
        vecs[8]  = '{64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000,  3'b101, 1'b0, 70'h7FFFFFFFFFFFFFFF8,     70'd1 << 66,   7'd1,  7'd66, 1'b0,1'b0,1'b0,1'b0,1'b0, 64'hFFFFFFFFFFFFFFFF, 3};
        vecs[9]  = '{64'd256,              64'd3,                 3'b101, 1'b0, 70'd1 << 65,               70'd3 << 65,   7'd5,  7'd58, 1'b0,1'b0,1'b0,1'b0,1'b0, 64'd256,              10};
        vecs[10] = '{64'hFFFFFFFF80000000, 64'h0000123400000001,  3'b101, 1'b1, 70'd1 << 65,               70'd1 << 66,   7'd17, 7'd34, 1'b0,1'b0,1'b0,1'b0,1'b0, 64'h0000000080000000, 10};
        vecs[11] = '{64'h8000000000000000, 64'd1,                 3'b100, 1'b0, 70'd1 << 65,               70'd1 << 66,   7'd33, 7'd2,  1'b0,1'b0,1'b0,1'b1,1'b0, 64'h8000000000000000, 10};

        bus.InValid        = 1'b0;
        bus.Abort          = 1'b0;
        bus.OutReady       = 1'b0;
        bus.ForwardedSrcAE = '0;
        bus.ForwardedSrcBE = '0;
        bus.Funct3E        = 3'b000;
        bus.W64E           = 1'b0;
        reset              = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all_zero("reset");

        for (int i = 0; i < NV; i++) run_vec(i);

        // Back-pressure: DONE holds its outputs and ignores new operands.
        begin
            int lat;
            start_op(64'd100, 64'd7, 3'b101, 1'b0);
            wait_valid(lat);
            check("bp latency", lat, 10);
            bus.ForwardedSrcAE = 64'd55;
            bus.ForwardedSrcBE = 64'd0;
            bus.InValid        = 1'b1;
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                check($sformatf("bp hold %0d", k),
                      {bus.OutValid, bus.InReady, bus.CyclesM, bus.IntNormShiftM, bus.X},
                      {1'b1, 1'b0, 7'd3, 7'd62, 70'd100 << 60});
            end
            bus.InValid  = 1'b0;
            release_out();
            check("bp released", {bus.OutValid, bus.InReady}, 2'b01);
            no_valid_for("bp no stray op", 4);
        end

        // Abort during the third NORM cycle.
        start_op(64'd100, 64'd7, 3'b101, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        bus.Abort = 1'b1;
        @(posedge clk); #1;
        bus.Abort = 1'b0;
        check("abort idle", {bus.OutValid, bus.InReady}, 2'b01);
        no_valid_for("abort no valid", 15);
        run_vec(0);

        // Reset while in ALIGN.
        start_op(64'd100, 64'd7, 3'b101, 1'b0);
        repeat (8) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_all_zero("rst align");
        no_valid_for("rst no valid", 15);
        run_vec(4);

        // Abort in IDLE blocks acceptance of a zero-operand op.
        bus.ForwardedSrcAE = 64'd5;
        bus.ForwardedSrcBE = 64'd0;
        bus.Funct3E        = 3'b111;
        bus.InValid        = 1'b1;
        bus.Abort          = 1'b1;
        @(posedge clk); #1;
        bus.InValid = 1'b0;
        bus.Abort   = 1'b0;
        check("idle abort blocks", {bus.OutValid, bus.InReady}, 2'b01);
        no_valid_for("idle abort no valid", 3);
        run_vec(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
